// File: rtl/compare_serial.sv
// compare_serial: bit-serial MSB-first unsigned magnitude comparator.
// The first differing bit locks the verdict; all N beats are always consumed.
module compare_serial #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic ready,
    output logic busy,
    output logic done_tick,
    output logic gt,
    output logic eq,
    output logic lt
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          gtf_q, ltf_q, gt_q, eq_q, lt_q;
    logic          gtf_d, ltf_d, last_beat;

    // flags only move while both are still clear, so the MSB-most difference wins
    always_comb begin
        gtf_d     = gtf_q | (~gtf_q & ~ltf_q & a_bit & ~b_bit);
        ltf_d     = ltf_q | (~gtf_q & ~ltf_q & ~a_bit & b_bit);
        last_beat = cnt_q == CW'(N - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gtf_q   <= 1'b0;
            ltf_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                    gtf_q   <= 1'b0;
                    ltf_q   <= 1'b0;
                    gt_q    <= 1'b0;
                    eq_q    <= 1'b0;
                    lt_q    <= 1'b0;
                end
                RUN: if (bit_valid) begin
                    gtf_q <= gtf_d;
                    ltf_q <= ltf_d;
                    cnt_q <= last_beat ? CW'(N) : cnt_q + CW'(1);
                    if (last_beat) begin
                        state_q <= DONE;
                        gt_q    <= gtf_d;
                        lt_q    <= ltf_d;
                        eq_q    <= ~gtf_d & ~ltf_d;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready     = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign done_tick = state_q == DONE;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial: scoreboard bench for an N=8 and an N=1 compare_serial.
module tb_compare_serial;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
    logic ready, busy, done_tick, gt, eq, lt;
    logic start1 = 1'b0, bv1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic ready1, busy1, done1, gt1, eq1, lt1;
    int checks = 0;
    int errors = 0;
    logic [2:0] q8[$];
    logic [2:0] q1[$];

    always #5 clk = ~clk;

    compare_serial #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .ready(ready), .busy(busy),
        .done_tick(done_tick), .gt(gt), .eq(eq), .lt(lt)
    );

    compare_serial #(.N(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .bit_valid(bv1),
        .a_bit(a1), .b_bit(b1), .ready(ready1), .busy(busy1),
        .done_tick(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    function automatic logic [2:0] expect_cmp(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? 3'b100 : (a < b) ? 3'b001 : 3'b010;
    endfunction

    always @(negedge clk) begin
        if (done_tick === 1'b1) begin
            logic [2:0] e;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_done got gt/eq/lt=%b required no done_tick", {gt, eq, lt});
            end else begin
                e = q8.pop_front();
                if ({gt, eq, lt} !== e) begin
                    errors++;
                    $display("FAIL sb8_result got gt/eq/lt=%b required %b", {gt, eq, lt}, e);
                end
            end
        end
        if (done1 === 1'b1) begin
            logic [2:0] e;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_done got gt/eq/lt=%b required no done_tick", {gt1, eq1, lt1});
            end else begin
                e = q1.pop_front();
                if ({gt1, eq1, lt1} !== e) begin
                    errors++;
                    $display("FAIL sb1_result got gt/eq/lt=%b required %b", {gt1, eq1, lt1}, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, busy, done_tick, gt, eq, lt} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state got %b required 100000", {ready, busy, done_tick, gt, eq, lt});
        end
        checks++;
        if ({ready1, busy1, done1, gt1, eq1, lt1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state_n1 got %b required 100000", {ready1, busy1, done1, gt1, eq1, lt1});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // one full N=8 compare; noise adds start pulses in RUN/DONE and bit_valid with start
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int s1, input int s2,
                        input int ns, input bit noise, input string name);
        int cyc;
        logic [2:0] e;
        e = expect_cmp(a, b);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before got %b required 1", name, ready);
        end
        start = 1'b1;
        bit_valid = noise;
        a_bit = ~b[7];
        b_bit = b[7];
        q8.push_back(e);
        @(negedge clk);
        cyc = 1;
        checks++;
        if ({gt, eq, lt, busy, ready} !== 5'b00010) begin
            errors++;
            $display("FAIL %s_cleared_on_start got gt/eq/lt/busy/ready=%b required 00010", name, {gt, eq, lt, busy, ready});
        end
        for (int i = 7; i >= 0; i--) begin
            start = noise;
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            @(negedge clk);
            cyc++;
            if (8 - i == s1 || 8 - i == s2) begin
                for (int k = 0; k < ns; k++) begin
                    bit_valid = 1'b0;
                    a_bit = $urandom_range(0, 1) == 1;
                    b_bit = ~a_bit;
                    checks++;
                    if (busy !== 1'b1 || done_tick !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_busy_stall got busy=%b done=%b required 1 0", name, busy, done_tick);
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        bit_valid = 1'b0;
        start = noise;
        checks++;
        if (done_tick !== 1'b1 || cyc != 9 + ((s1 > 0) ? ns : 0) + ((s2 > 0) ? ns : 0)) begin
            errors++;
            $display("FAIL %s_done_latency got done=%b cyc=%0d required done=1 cyc=%0d", name, done_tick, cyc,
                     9 + ((s1 > 0) ? ns : 0) + ((s2 > 0) ? ns : 0));
        end
        checks++;
        if ({ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s_done_flags got ready/busy=%b required 00", name, {ready, busy});
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done_tick !== 1'b0 || ready !== 1'b1 || {gt, eq, lt} !== e) begin
            errors++;
            $display("FAIL %s_idle_hold got done=%b ready=%b gt/eq/lt=%b required 0 1 %b", name, done_tick, ready, {gt, eq, lt}, e);
        end
        bit_valid = 1'b1;
        repeat (2) @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if ({gt, eq, lt} !== e || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_held got gt/eq/lt=%b ready=%b required %b 1", name, {gt, eq, lt}, ready, e);
        end
    endtask

    task automatic test_equal();
        run8(8'hA5, 8'hA5, 0, 0, 0, 1'b0, "eq_a5");
    endtask

    task automatic test_msb();
        run8(8'h80, 8'h7F, 0, 0, 0, 1'b0, "gt_msb");
        run8(8'h7F, 8'h80, 0, 0, 0, 1'b0, "lt_msb");
    endtask

    task automatic test_stalls();
        run8(8'h3C, 8'h3D, 2, 5, 3, 1'b0, "lt_stall");
    endtask

    task automatic test_ignored();
        run8(8'h5A, 8'h59, 0, 0, 0, 1'b1, "noise_gt");
        run8(8'h12, 8'h34, 3, 0, 2, 1'b1, "noise_lt");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = (t == 2) ? a : 8'($urandom);
            run8(a, b, 0, 0, 0, 1'b0, "b2b");
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a_bit = 1'b0;
            b_bit = 1'b1;
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({ready, busy, done_tick, gt, eq, lt} !== 6'b100000) begin
            errors++;
            $display("FAIL abort_state got %b required 100000", {ready, busy, done_tick, gt, eq, lt});
        end
        for (int i = 0; i < 8; i++) @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if ({ready, done_tick} !== 2'b10) begin
            errors++;
            $display("FAIL abort_no_done got ready/done=%b required 10", {ready, done_tick});
        end
        run8(8'hFF, 8'h00, 0, 0, 0, 1'b0, "after_abort");
    endtask

    task automatic n1_beat(input logic a, input logic b, input string name);
        logic [2:0] e;
        e = (a & ~b) ? 3'b100 : (~a & b) ? 3'b001 : 3'b010;
        start1 = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        bv1 = 1'b1;
        a1 = a;
        b1 = b;
        @(negedge clk);
        bv1 = 1'b0;
        checks++;
        if (done1 !== 1'b1 || {gt1, eq1, lt1} !== e) begin
            errors++;
            $display("FAIL %s got done=%b gt/eq/lt=%b required 1 %b", name, done1, {gt1, eq1, lt1}, e);
        end
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got ready=%b done=%b required 1 0", name, ready1, done1);
        end
    endtask

    task automatic test_n1();
        n1_beat(1'b1, 1'b0, "n1_gt");
        n1_beat(1'b0, 1'b0, "n1_eq");
        n1_beat(1'b0, 1'b1, "n1_lt");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_stalls();
        test_ignored();
        test_back_to_back();
        test_abort();
        test_n1();
        repeat (2) @(negedge clk);
        checks++;
        if (q8.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", q8.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
